// File: rtl/record_play_sequencer_pkg.sv
// Shared encodings and default widths for the record/play sequencer.
// The defaults must stay in step with the music memory parameter header.
package record_play_sequencer_pkg;

   localparam int SEL_W_DEF     = 3;
   localparam int DEPTH_W_DEF   = 10;
   localparam int PRE_COUNT_DEF = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECORD = 3'd1,
      ST_REVIEW = 3'd2,
      ST_PLAY   = 3'd3,
      ST_STROBE = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_STOP,
      CMD_SAVE,
      CMD_DISCARD,
      CMD_DELETE,
      CMD_PLAY,
      CMD_RECORD
   } cmd_t;

   typedef enum logic [1:0] {
      STB_SAVE,
      STB_DISCARD,
      STB_DELETE
   } strobe_t;

   // Only the highest-priority command of a cycle is ever evaluated.
   function automatic cmd_t pick_cmd(input logic stop, input logic save,
                                     input logic discard, input logic delete,
                                     input logic play, input logic record);
      if (stop)         return CMD_STOP;
      else if (save)    return CMD_SAVE;
      else if (discard) return CMD_DISCARD;
      else if (delete)  return CMD_DELETE;
      else if (play)    return CMD_PLAY;
      else if (record)  return CMD_RECORD;
      else              return CMD_NONE;
   endfunction

endpackage

// File: rtl/record_play_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the music memory (slave).
interface record_play_sequencer_if
   import record_play_sequencer_pkg::*;
#(
   parameter int SEL_W   = SEL_W_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF
);

   logic                  write_en;
   logic                  read_en;
   logic                  read_rst;
   logic [SEL_W-1:0]      select;
   logic                  save;
   logic                  discard;
   logic                  delete;
   logic [2**SEL_W-1:0]   mem_status;
   logic [DEPTH_W-1:0]    mem_duration;

   modport master (
      output write_en, read_en, read_rst, select, save, discard, delete,
      input  mem_status, mem_duration
   );

   modport slave (
      input  write_en, read_en, read_rst, select, save, discard, delete,
      output mem_status, mem_duration
   );

endinterface

// File: rtl/record_play_sequencer_step_timer.sv
// Free-running step pacer: ticks once every STEP_CYCLES enabled cycles.
module step_timer #(
   parameter int STEP_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= (count_q == LAST) ? '0 : count_q + CW'(1);
      end
   end

   assign tick = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/record_play_sequencer.sv
// Turns front-panel command pulses into the music memory's level/pulse controls.
// Commands are one-cycle pulses with no backpressure; an illegal winner answers with reject next cycle.
module record_play_sequencer
   import record_play_sequencer_pkg::*;
#(
   parameter int SEL_W       = SEL_W_DEF,
   parameter int DEPTH_W     = DEPTH_W_DEF,
   parameter int PRE_COUNT   = PRE_COUNT_DEF,
   parameter int STEP_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_record,
   input  logic                   cmd_stop,
   input  logic                   cmd_play,
   input  logic                   cmd_save,
   input  logic                   cmd_discard,
   input  logic                   cmd_delete,
   input  logic [SEL_W-1:0]       sel_in,
   record_play_sequencer_if.master mem,
   output logic [2:0]             state,
   output logic [DEPTH_W-1:0]     step_count,
   output logic                   reject
);

   localparam int                 HOLD_W    = (2 * HOLD_CYCLES > 2) ? $clog2(2 * HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_ON   = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]  HOLD_END  = HOLD_W'(2 * HOLD_CYCLES - 1);
   localparam logic [SEL_W:0]     PRE_LIM   = (SEL_W + 1)'(PRE_COUNT);
   localparam logic [DEPTH_W-1:0] COUNT_MAX = '1;

   state_t              state_q;
   strobe_t             kind_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [SEL_W-1:0]    sel_q;
   logic [DEPTH_W-1:0]  step_count_q;
   logic                read_en_q;
   logic                read_rst_q;
   logic                reject_q;

   cmd_t                cmd;
   logic                sel_has_data;
   logic                del_ok;
   logic [DEPTH_W-1:0]  count_inc;
   logic                timer_clear;
   logic                timer_en;
   logic                tick;

   always_comb begin
      cmd          = pick_cmd(cmd_stop, cmd_save, cmd_discard, cmd_delete, cmd_play, cmd_record);
      sel_has_data = mem.mem_status[sel_in];
      del_ok       = ({1'b0, sel_in} >= PRE_LIM) && sel_has_data;
      count_inc    = (step_count_q == COUNT_MAX) ? COUNT_MAX : step_count_q + DEPTH_W'(1);
      timer_en     = (state_q == ST_RECORD) || (state_q == ST_PLAY);
      timer_clear  = (state_q == ST_IDLE) &&
                     ((cmd == CMD_RECORD) || ((cmd == CMD_PLAY) && sel_has_data));
   end

   step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_en),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         kind_q       <= STB_SAVE;
         hold_q       <= '0;
         sel_q        <= '0;
         step_count_q <= '0;
         read_en_q    <= 1'b0;
         read_rst_q   <= 1'b0;
         reject_q     <= 1'b0;
      end else begin
         read_en_q  <= 1'b0;
         read_rst_q <= 1'b0;
         reject_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               case (cmd)
                  CMD_NONE: ;
                  CMD_RECORD: begin
                     state_q      <= ST_RECORD;
                     step_count_q <= '0;
                  end
                  CMD_PLAY: begin
                     if (sel_has_data) begin
                        state_q      <= ST_PLAY;
                        sel_q        <= sel_in;
                        read_rst_q   <= 1'b1;
                        step_count_q <= '0;
                     end else begin
                        reject_q <= 1'b1;
                     end
                  end
                  CMD_DELETE: begin
                     if (del_ok) begin
                        state_q <= ST_STROBE;
                        sel_q   <= sel_in;
                        kind_q  <= STB_DELETE;
                        hold_q  <= '0;
                     end else begin
                        reject_q <= 1'b1;
                     end
                  end
                  default: reject_q <= 1'b1;
               endcase
            end
            ST_RECORD: begin
               if (cmd == CMD_STOP) begin
                  state_q <= ST_REVIEW;
               end else begin
                  if (cmd != CMD_NONE) reject_q <= 1'b1;
                  if (tick) begin
                     step_count_q <= count_inc;
                     if (count_inc == COUNT_MAX) state_q <= ST_REVIEW;
                  end
               end
            end
            ST_REVIEW: begin
               case (cmd)
                  CMD_NONE: ;
                  CMD_SAVE: begin
                     if (step_count_q != '0) begin
                        state_q <= ST_STROBE;
                        kind_q  <= STB_SAVE;
                        hold_q  <= '0;
                     end else begin
                        reject_q <= 1'b1;
                     end
                  end
                  CMD_DISCARD: begin
                     state_q <= ST_STROBE;
                     kind_q  <= STB_DISCARD;
                     hold_q  <= '0;
                  end
                  default: reject_q <= 1'b1;
               endcase
            end
            ST_PLAY: begin
               if (cmd == CMD_STOP) begin
                  state_q <= ST_IDLE;
               end else begin
                  if (cmd != CMD_NONE) reject_q <= 1'b1;
                  // A zero (or already reached) duration ends playback without a read.
                  if (tick) begin
                     step_count_q <= count_inc;
                     read_en_q    <= 1'b1;
                     if (count_inc >= mem.mem_duration) state_q <= ST_IDLE;
                  end else if (step_count_q >= mem.mem_duration) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_STROBE: begin
               if (cmd != CMD_NONE) reject_q <= 1'b1;
               if (hold_q == HOLD_END) begin
                  state_q <= ST_IDLE;
               end else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Strobes decode from registered state so they fall with the async reset.
   logic strobe_on;
   assign strobe_on    = (state_q == ST_STROBE) && (hold_q < HOLD_ON);

   assign mem.write_en = (state_q == ST_RECORD);
   assign mem.read_en  = read_en_q;
   assign mem.read_rst = read_rst_q;
   assign mem.select   = (state_q == ST_IDLE) ? sel_in : sel_q;
   assign mem.save     = strobe_on && (kind_q == STB_SAVE);
   assign mem.discard  = strobe_on && (kind_q == STB_DISCARD);
   assign mem.delete   = strobe_on && (kind_q == STB_DELETE);

   assign state      = state_q;
   assign step_count = step_count_q;
   assign reject     = reject_q;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Directed bench: drivers push expected events, a negedge monitor pops and compares them.
module tb_record_play_sequencer;

   localparam int SEL_W   = 3;
   localparam int DEPTH_W = 10;
   localparam int W       = 20;

   localparam logic [3:0] EV_STATE = 4'd1;
   localparam logic [3:0] EV_RRST  = 4'd2;
   localparam logic [3:0] EV_REN   = 4'd3;
   localparam logic [3:0] EV_REJ   = 4'd4;
   localparam logic [3:0] EV_WR    = 4'd5;
   localparam logic [3:0] EV_SAVE  = 4'd6;
   localparam logic [3:0] EV_DISC  = 4'd7;
   localparam logic [3:0] EV_DEL   = 4'd8;

   localparam logic [5:0] M_REC  = 6'b100000;
   localparam logic [5:0] M_STOP = 6'b010000;
   localparam logic [5:0] M_PLAY = 6'b001000;
   localparam logic [5:0] M_SAVE = 6'b000100;
   localparam logic [5:0] M_DISC = 6'b000010;
   localparam logic [5:0] M_DEL  = 6'b000001;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_record = 1'b0, cmd_stop = 1'b0, cmd_play = 1'b0;
   logic               cmd_save = 1'b0, cmd_discard = 1'b0, cmd_delete = 1'b0;
   logic [SEL_W-1:0]   sel_in = '0;
   logic [2:0]         dut_state;
   logic [DEPTH_W-1:0] step_count;
   logic               reject;

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic         mon_en = 1'b0;

   record_play_sequencer_if #(.SEL_W(SEL_W), .DEPTH_W(DEPTH_W)) mem_if ();

   record_play_sequencer #(
      .SEL_W(SEL_W), .DEPTH_W(DEPTH_W), .PRE_COUNT(5),
      .STEP_CYCLES(4), .HOLD_CYCLES(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_record(cmd_record), .cmd_stop(cmd_stop), .cmd_play(cmd_play),
      .cmd_save(cmd_save), .cmd_discard(cmd_discard), .cmd_delete(cmd_delete),
      .sel_in(sel_in), .mem(mem_if),
      .state(dut_state), .step_count(step_count), .reject(reject)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic pulse(input logic [5:0] m);
      {cmd_record, cmd_stop, cmd_play, cmd_save, cmd_discard, cmd_delete} = m;
      @(posedge clk);
      #1;
      {cmd_record, cmd_stop, cmd_play, cmd_save, cmd_discard, cmd_delete} = 6'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_ev(input logic [3:0] code, input logic [15:0] data);
      exp_q.push_back({code, data});
   endtask

   task automatic exp_st(input logic [2:0] st, input logic [5:0] dwell, input logic [6:0] cnt);
      exp_q.push_back({EV_STATE, st, dwell, cnt});
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   task automatic see(input logic [W-1:0] got);
      logic [W-1:0] want;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got=%h expected=none t=%0t", got, $time);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL event got=%h expected=%h t=%0t", got, want, $time);
         end
      end
   endtask

   // ---------------- monitor ----------------
   logic [2:0] m_prev;
   int         m_dwell, m_gap, m_wr, m_sv, m_dc, m_dl;

   initial begin
      m_prev = 3'd0; m_dwell = 0; m_gap = 0;
      m_wr = 0; m_sv = 0; m_dc = 0; m_dl = 0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (dut_state != m_prev) begin
            see({EV_STATE, dut_state, (m_prev == 3'd0) ? 6'd0 : 6'(m_dwell), step_count[6:0]});
            m_prev  = dut_state;
            m_dwell = 1;
         end else if (m_dwell < 63) begin
            m_dwell++;
         end
         if (mem_if.read_rst) begin
            m_gap = 0;
            see({EV_RRST, 16'(mem_if.select)});
         end else if (m_gap < 1000) begin
            m_gap++;
         end
         if (mem_if.read_en) see({EV_REN, 16'(m_gap)});
         if (reject) see({EV_REJ, 16'(dut_state)});
         if (mem_if.write_en) m_wr++;
         else if (m_wr != 0) begin see({EV_WR, 16'(m_wr)}); m_wr = 0; end
         if (mem_if.save) m_sv++;
         else if (m_sv != 0) begin see({EV_SAVE, 16'(m_sv)}); m_sv = 0; end
         if (mem_if.discard) m_dc++;
         else if (m_dc != 0) begin see({EV_DISC, 16'(m_dc)}); m_dc = 0; end
         if (mem_if.delete) m_dl++;
         else if (m_dl != 0) begin see({EV_DEL, 16'(m_dl)}); m_dl = 0; end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      mem_if.mem_status   = 8'h3F;
      mem_if.mem_duration = 10'd3;
      sel_in              = 3'd3;
      #22;
      check_val("rst_state", 32'(dut_state), 32'd0);
      check_val("rst_write_en", 32'(mem_if.write_en), 32'd0);
      check_val("rst_read_en", 32'(mem_if.read_en), 32'd0);
      check_val("rst_read_rst", 32'(mem_if.read_rst), 32'd0);
      check_val("rst_strobes", 32'({mem_if.save, mem_if.discard, mem_if.delete}), 32'd0);
      check_val("rst_reject", 32'(reject), 32'd0);
      check_val("rst_step_count", 32'(step_count), 32'd0);
      check_val("rst_select_live", 32'(mem_if.select), 32'd3);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // record 22 cycles, then save
      exp_st(3'd1, 6'd0, 7'd0);
      exp_st(3'd2, 6'd22, 7'd5);
      exp_ev(EV_WR, 16'd22);
      exp_st(3'd4, 6'd1, 7'd5);
      exp_ev(EV_SAVE, 16'd3);
      exp_st(3'd0, 6'd6, 7'd5);
      pulse(M_REC);
      idle(21);
      pulse(M_STOP);
      check_val("review_state", 32'(dut_state), 32'd2);
      check_val("review_count", 32'(step_count), 32'd5);
      pulse(M_SAVE);
      idle(8);

      // playback of unit 5, duration 3
      sel_in = 3'd5;
      exp_st(3'd3, 6'd0, 7'd0);
      exp_ev(EV_RRST, 16'd5);
      exp_ev(EV_REN, 16'd4);
      exp_ev(EV_REN, 16'd8);
      exp_st(3'd0, 6'd12, 7'd3);
      exp_ev(EV_REN, 16'd12);
      pulse(M_PLAY);
      idle(16);
      check_val("play_end_count", 32'(step_count), 32'd3);

      // delete: prewritten unit, empty unit, then a legal one
      exp_ev(EV_REJ, 16'd0);
      exp_ev(EV_REJ, 16'd0);
      exp_st(3'd4, 6'd0, 7'd3);
      exp_ev(EV_DEL, 16'd3);
      exp_st(3'd0, 6'd6, 7'd3);
      sel_in = 3'd2; pulse(M_DEL);
      sel_in = 3'd6; pulse(M_DEL);
      sel_in = 3'd5; pulse(M_DEL);
      sel_in = 3'd0;
      #1;
      check_val("strobe_select_latched", 32'(mem_if.select), 32'd5);
      idle(8);

      // play+stop in PLAY, then record during STROBE
      mem_if.mem_duration = 10'd10;
      sel_in = 3'd5;
      exp_st(3'd3, 6'd0, 7'd0);
      exp_ev(EV_RRST, 16'd5);
      exp_st(3'd0, 6'd2, 7'd0);
      pulse(M_PLAY);
      idle(1);
      pulse(M_PLAY | M_STOP);
      idle(3);
      exp_st(3'd4, 6'd0, 7'd0);
      exp_ev(EV_REJ, 16'd4);
      exp_ev(EV_DEL, 16'd3);
      exp_st(3'd0, 6'd6, 7'd0);
      pulse(M_DEL);
      pulse(M_REC);
      check_val("strobe_after_record", 32'(dut_state), 32'd4);
      idle(8);

      // illegal commands in IDLE, including priority drops
      exp_ev(EV_REJ, 16'd0);
      exp_ev(EV_REJ, 16'd0);
      exp_ev(EV_REJ, 16'd0);
      exp_ev(EV_REJ, 16'd0);
      exp_ev(EV_REJ, 16'd0);
      sel_in = 3'd7; pulse(M_PLAY);
      pulse(M_STOP);
      pulse(M_SAVE | M_REC);
      sel_in = 3'd4; pulse(M_DEL);
      sel_in = 3'd5; pulse(M_DISC | M_PLAY);
      idle(3);
      check_val("idle_after_rejects", 32'(dut_state), 32'd0);

      // zero duration playback
      mem_if.mem_duration = 10'd0;
      exp_st(3'd3, 6'd0, 7'd0);
      exp_ev(EV_RRST, 16'd5);
      exp_st(3'd0, 6'd1, 7'd0);
      pulse(M_PLAY);
      idle(8);

      // reset during a save strobe
      exp_st(3'd1, 6'd0, 7'd0);
      exp_st(3'd2, 6'd6, 7'd1);
      exp_ev(EV_WR, 16'd6);
      exp_st(3'd4, 6'd1, 7'd1);
      exp_st(3'd0, 6'd2, 7'd0);
      exp_ev(EV_SAVE, 16'd2);
      pulse(M_REC);
      idle(5);
      pulse(M_STOP);
      pulse(M_SAVE);
      idle(2);
      check_val("save_high_before_reset", 32'(mem_if.save), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("reset_save_drop", 32'(mem_if.save), 32'd0);
      check_val("reset_state", 32'(dut_state), 32'd0);
      check_val("reset_count", 32'(step_count), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // empty take: save rejected, discard accepted
      exp_st(3'd1, 6'd0, 7'd0);
      exp_st(3'd2, 6'd2, 7'd0);
      exp_ev(EV_WR, 16'd2);
      exp_ev(EV_REJ, 16'd2);
      exp_st(3'd4, 6'd2, 7'd0);
      exp_ev(EV_DISC, 16'd3);
      exp_st(3'd0, 6'd6, 7'd0);
      pulse(M_REC);
      idle(1);
      pulse(M_STOP);
      pulse(M_SAVE);
      pulse(M_DISC);
      idle(10);

      // ---------------- report ----------------
      while (exp_q.size() != 0) begin
         logic [W-1:0] miss;
         miss = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event got=none expected=%h", miss);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/record_play_sequencer.md
# record_play_sequencer

Command-level controller that sequences the shared music memory block. It turns single-cycle user commands (record, stop, play, save, discard, delete) into the memory's level and pulse controls: `write_en`, `read_en`, `read_rst`, `select`, `save`, `discard` and `delete`. It paces record and playback steps with an internal step timer. It sits between the debounced front-panel logic and the memory block, and is the only driver of those memory inputs.

## Interface
- `SEL_W`, 3: width of the unit select; 2**SEL_W units.
- `DEPTH_W`, 10: width of step count and duration.
- `PRE_COUNT`, 5: units 0..PRE_COUNT-1 are prewritten and never deletable.
- `STEP_CYCLES`, 1_000_000: clk cycles per record/playback step (≥2).
- `HOLD_CYCLES`, 16: cycles a save/discard/delete line is held high, and also the released gap after it.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_record`, `cmd_stop`, `cmd_play`, `cmd_save`, `cmd_discard`, `cmd_delete`  in  1 each  single-cycle command pulses, already debounced.
- `sel_in`  in  SEL_W  user-selected unit.
- `mem_status`  in  2**SEL_W  per-unit has-data flags from memory.
- `mem_duration`  in  DEPTH_W  duration of the unit currently on `select`.
- `write_en`  out  1  record enable, level.
- `read_en`  out  1  one-cycle pulse per playback step.
- `read_rst`  out  1  one-cycle read-pointer reset.
- `select`  out  SEL_W  unit driven to memory.
- `save`, `discard`, `delete`  out  1 each  held-level strobes.
- `state`  out  3  current FSM state.
- `step_count`  out  DEPTH_W  steps recorded or played.
- `reject`  out  1  one-cycle pulse: a command was illegal in the current state.

## Operation
- States: IDLE=0, RECORD=1, REVIEW=2, PLAY=3, STROBE=4. All other encodings go to IDLE.
- Command priority within one cycle: stop > save > discard > delete > play > record. Only the highest command present is evaluated. Lower commands are dropped silently; `reject` fires only if the winning command is illegal.
- IDLE: `select` follows `sel_in` live.
  - record → RECORD, `step_count`=0.
  - play with `mem_status[sel_in]`=1 → latch select, pulse `read_rst`, `step_count`=0, go to PLAY. With status 0 → `reject`.
  - delete with `sel_in`≥PRE_COUNT and status 1 → latch select, STROBE(delete). Otherwise → `reject`.
  - stop/save/discard → `reject`.
- RECORD: `write_en`=1. Each step tick increments `step_count`. Stop, or `step_count` reaching 2**DEPTH_W-1 → REVIEW. Any other command → `reject`.
- REVIEW: `write_en`=0.
  - save with `step_count`≠0 → STROBE(save). Save with `step_count`=0 → `reject`.
  - discard → STROBE(discard).
  - stop/play/record/delete → `reject`.
- PLAY: `read_en` pulses on each step tick and `step_count` increments. When the incremented count equals `mem_duration` → IDLE. Stop → IDLE immediately. `mem_duration`=0 on entry → IDLE on the next cycle with no `read_en`. Any other command → `reject`.
- STROBE: the selected strobe line is high for HOLD_CYCLES, then low for HOLD_CYCLES, then → IDLE. Every command arriving in STROBE → `reject`.
- Select latched in PLAY/STROBE. In RECORD/REVIEW, `select` holds the last latched value.

## Timing
- Reset values: state IDLE; `write_en`, `read_en`, `read_rst`, `save`, `discard`, `delete`, `reject` = 0; `step_count`=0; step timer=0; select latch=0. `select` shows `sel_in` in IDLE.
- Reset mid-operation aborts immediately. Any held strobe drops asynchronously with `rst_n`.
- A command sampled at edge N changes `state` after edge N. `write_en`, `save`, `discard` and `delete` are decoded from registered state, so they are valid the cycle after acceptance.
- `read_rst` and `reject` are registered and high for exactly the cycle after the causing command.
- Step timer counts 0..STEP_CYCLES-1. It clears on entry to RECORD or PLAY and ticks when the count equals STEP_CYCLES-1.
  - First `read_en` comes STEP_CYCLES cycles after PLAY entry.
  - First record increment comes STEP_CYCLES cycles after RECORD entry.
- `step_count` saturates and never wraps.
- STROBE lasts exactly 2·HOLD_CYCLES cycles.

## Structure
- Shared package holds: the state encoding constants, and SEL_W/DEPTH_W/PRE_COUNT defaults. These must match the memory parameter header.
- One sub-module, `step_timer`: inputs clear and enable, output tick, parameter STEP_CYCLES.
- The strobe hold counter stays inline. It is 2·HOLD_CYCLES wide enough (clog2).

## Test plan
All scenarios use STEP_CYCLES=4, HOLD_CYCLES=3.
- Reset, then record; stop after 22 cycles → `write_en` high for 22 cycles, `step_count`=5, state=REVIEW; save → `save` high 3 cycles, low 3, then IDLE.
- `mem_status`=8'h3F, `sel_in`=5, `mem_duration`=3, play → `read_rst` 1 pulse, `read_en` pulses at +4/+8/+12 cycles, then IDLE with `step_count`=3.
- Delete with `sel_in`=2, then with `sel_in`=6 and status 0 → `reject` twice, `delete` never high; with `sel_in`=5 and status 1 → `delete` high 3 cycles.
- Same-cycle play+stop in PLAY → stop wins, IDLE next cycle, no `reject`; record during STROBE → `reject`, state unchanged.
- `rst_n` low during STROBE(save) at hold cycle 2 → `save` drops at once, state=IDLE, `step_count`=0.
- Save in REVIEW with `step_count`=0 (stop in the same cycle as the first tick is impossible, so force via stop at cycle 2) → `reject`; discard → `discard` held 3 cycles.
